// File: rtl/swervolf_sevseg_pkg.sv
// Shared constants for the SweRVolf seven-segment controller: register map,
// CTRL field positions, hex glyph table and the byte-lane merge helper.
package swervolf_sevseg_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_DIG_EN    = 3'd1;
  localparam logic [2:0] REG_DP        = 3'd2;
  localparam logic [2:0] REG_RAW_MODE  = 3'd3;
  localparam logic [2:0] REG_DIGITS_LO = 3'd4;
  localparam logic [2:0] REG_DIGITS_HI = 3'd5;
  localparam logic [2:0] REG_RAW_WR    = 3'd6;
  localparam logic [2:0] REG_STATUS    = 3'd7;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_GAP_BIT    = 8;
  localparam logic [8:0] CTRL_WR_MASK = 9'h1F1;

  // Active-high {a,b,c,d,e,f,g}; entry 15 is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [31:0] wb_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_val & ~m) | (wdat & m);
  endfunction

endpackage

// File: rtl/swervolf_sevseg_if.sv
// Wishbone slave bundle for the seven-segment controller.
interface swervolf_sevseg_if;
  import swervolf_sevseg_pkg::*;

  logic [WB_AW-1:0] i_wb_adr;
  logic [WB_DW-1:0] i_wb_dat;
  logic [3:0]       i_wb_sel;
  logic             i_wb_we;
  logic             i_wb_cyc;
  logic             i_wb_stb;
  logic [WB_DW-1:0] o_wb_rdt;
  logic             o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/swervolf_sevseg_decoder.sv
// Combinational hex nibble to active-high segment pattern.
module swervolf_sevseg_decoder
  import swervolf_sevseg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/swervolf_sevseg_ctrl.sv
// Wishbone-mapped multiplexed seven-segment controller with frame-synchronous
// shadow registers, PWM brightness and an optional inter-digit blanking gap.
module swervolf_sevseg_ctrl
  import swervolf_sevseg_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 16384,
  parameter int BLANK_CYC = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  swervolf_sevseg_if.slave    wb,
  output logic [N_DIGITS-1:0] o_an,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic                o_frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0]    IDX_MAX = 4'(N_DIGITS - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);

  logic                     ack_q, ack_d;
  logic [31:0]              rdt_q, rdt_d;
  logic [8:0]               ctrl_q, ctrl_d;
  logic [N_DIGITS-1:0]      dig_en_q, dig_en_d, dp_en_q, dp_en_d, raw_mode_q, raw_mode_d;
  logic [31:0]              digits_lo_q, digits_lo_d, digits_hi_q, digits_hi_d;
  logic [N_DIGITS-1:0][6:0] raw_q, raw_d;
  logic [3:0]               raw_idx_q, raw_idx_d;

  logic [3:0]               sh_bright_q, sh_bright_d;
  logic                     sh_gap_q, sh_gap_d;
  logic [N_DIGITS-1:0]      sh_dig_en_q, sh_dig_en_d, sh_dp_en_q, sh_dp_en_d;
  logic [N_DIGITS-1:0]      sh_raw_mode_q, sh_raw_mode_d;
  logic [63:0]              sh_digits_q, sh_digits_d;
  logic [N_DIGITS-1:0][6:0] sh_raw_q, sh_raw_d;

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               idx_q, idx_d;
  logic [7:0]               frame_cnt_q, frame_cnt_d;
  logic [N_DIGITS-1:0]      an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_out_q, dp_out_d, frame_q, frame_d;

  logic        req, wr, en, frame_bnd, raw_wr_ok, lit;
  logic [2:0]  reg_sel;
  logic [3:0]  raw_wr_idx, sub;
  logic [31:0] rd_val;
  logic [6:0]  hex_seg, seg_src;
  logic [15:0] dig_en16, dp_en16, raw_mode16;
  logic [15:0][6:0] raw16;
  logic        unused_adr;

  assign unused_adr = ^wb.i_wb_adr[1:0];
  assign req        = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
  assign wr         = req & wb.i_wb_we;
  assign reg_sel    = wb.i_wb_adr[4:2];
  assign raw_wr_idx = wb.i_wb_dat[11:8];
  assign raw_wr_ok  = wr & (reg_sel == REG_RAW_WR) & (&wb.i_wb_sel[1:0]) &
                      ({28'd0, raw_wr_idx} < 32'(N_DIGITS));
  assign en         = ctrl_q[CTRL_EN_BIT];
  assign frame_bnd  = en & (cnt_q == CNT_MAX) & (idx_q == IDX_MAX);

  always_comb begin
    ack_d       = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
    ctrl_d      = ctrl_q;
    dig_en_d    = dig_en_q;
    dp_en_d     = dp_en_q;
    raw_mode_d  = raw_mode_q;
    digits_lo_d = digits_lo_q;
    digits_hi_d = digits_hi_q;
    raw_idx_d   = raw_wr_ok ? raw_wr_idx : raw_idx_q;
    if (wr) begin
      case (reg_sel)
        REG_CTRL:      ctrl_d      = 9'(wb_merge(32'(ctrl_q), wb.i_wb_dat, wb.i_wb_sel)) & CTRL_WR_MASK;
        REG_DIG_EN:    dig_en_d    = N_DIGITS'(wb_merge(32'(dig_en_q), wb.i_wb_dat, wb.i_wb_sel));
        REG_DP:        dp_en_d     = N_DIGITS'(wb_merge(32'(dp_en_q), wb.i_wb_dat, wb.i_wb_sel));
        REG_RAW_MODE:  raw_mode_d  = N_DIGITS'(wb_merge(32'(raw_mode_q), wb.i_wb_dat, wb.i_wb_sel));
        REG_DIGITS_LO: digits_lo_d = wb_merge(digits_lo_q, wb.i_wb_dat, wb.i_wb_sel);
        REG_DIGITS_HI: digits_hi_d = wb_merge(digits_hi_q, wb.i_wb_dat, wb.i_wb_sel);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CTRL:      rd_val = 32'(ctrl_q);
      REG_DIG_EN:    rd_val = 32'(dig_en_q);
      REG_DP:        rd_val = 32'(dp_en_q);
      REG_RAW_MODE:  rd_val = 32'(raw_mode_q);
      REG_DIGITS_LO: rd_val = digits_lo_q;
      REG_DIGITS_HI: rd_val = digits_hi_q;
      REG_RAW_WR:    rd_val = {20'd0, raw_idx_q, 8'd0};
      REG_STATUS:    rd_val = {16'd0, frame_cnt_q, 4'd0, idx_q};
    endcase
    rdt_d = req ? rd_val : rdt_q;
  end

  // At a boundary the shadows take the pre-write live value; while disabled
  // they follow the incoming value so enabling shows the new settings at once.
  always_comb begin
    sh_bright_d   = sh_bright_q;
    sh_gap_d      = sh_gap_q;
    sh_dig_en_d   = sh_dig_en_q;
    sh_dp_en_d    = sh_dp_en_q;
    sh_raw_mode_d = sh_raw_mode_q;
    sh_digits_d   = sh_digits_q;
    if (frame_bnd) begin
      sh_bright_d   = ctrl_q[CTRL_BRIGHT_LSB +: 4];
      sh_gap_d      = ctrl_q[CTRL_GAP_BIT];
      sh_dig_en_d   = dig_en_q;
      sh_dp_en_d    = dp_en_q;
      sh_raw_mode_d = raw_mode_q;
      sh_digits_d   = {digits_hi_q, digits_lo_q};
    end else if (!en) begin
      sh_bright_d   = ctrl_d[CTRL_BRIGHT_LSB +: 4];
      sh_gap_d      = ctrl_d[CTRL_GAP_BIT];
      sh_dig_en_d   = dig_en_d;
      sh_dp_en_d    = dp_en_d;
      sh_raw_mode_d = raw_mode_d;
      sh_digits_d   = {digits_hi_d, digits_lo_d};
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_raw
    assign raw_d[gi]    = (raw_wr_ok && raw_wr_idx == 4'(gi)) ? wb.i_wb_dat[6:0] : raw_q[gi];
    assign sh_raw_d[gi] = frame_bnd ? raw_q[gi] : (!en ? raw_d[gi] : sh_raw_q[gi]);
  end

  assign dig_en16   = 16'(sh_dig_en_q);
  assign dp_en16    = 16'(sh_dp_en_q);
  assign raw_mode16 = 16'(sh_raw_mode_q);
  assign raw16      = (16 * 7)'(sh_raw_q);
  assign sub        = cnt_q[CW-1 -: 4];

  swervolf_sevseg_decoder u_dec (
    .i_nib (sh_digits_q[{idx_q, 2'b00} +: 4]),
    .o_seg (hex_seg)
  );

  always_comb begin
    cnt_d       = en ? cnt_q + 1'b1 : '0;
    idx_d       = idx_q;
    frame_cnt_d = frame_bnd ? frame_cnt_q + 8'd1 : frame_cnt_q;
    if (!en)
      idx_d = '0;
    else if (cnt_q == CNT_MAX)
      idx_d = (idx_q == IDX_MAX) ? 4'd0 : idx_q + 4'd1;
    lit      = en & dig_en16[idx_q] & (sub <= sh_bright_q) & (~sh_gap_q | (cnt_q >= BLANK));
    seg_src  = raw_mode16[idx_q] ? raw16[idx_q] : hex_seg;
    an_d     = lit ? ~(N_DIGITS'(1) << idx_q) : '1;
    seg_d    = lit ? ~seg_src : 7'h7F;
    dp_out_d = lit ? ~dp_en16[idx_q] : 1'b1;
    frame_d  = en & (idx_q == 4'd0) & (cnt_q == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q <= 1'b0;         rdt_q <= '0;          ctrl_q <= '0;
      dig_en_q <= '0;        dp_en_q <= '0;        raw_mode_q <= '0;
      digits_lo_q <= '0;     digits_hi_q <= '0;    raw_q <= '0;
      raw_idx_q <= '0;       sh_bright_q <= '0;    sh_gap_q <= 1'b0;
      sh_dig_en_q <= '0;     sh_dp_en_q <= '0;     sh_raw_mode_q <= '0;
      sh_digits_q <= '0;     sh_raw_q <= '0;       cnt_q <= '0;
      idx_q <= '0;           frame_cnt_q <= '0;    an_q <= '1;
      seg_q <= 7'h7F;        dp_out_q <= 1'b1;     frame_q <= 1'b0;
    end else begin
      ack_q <= ack_d;        rdt_q <= rdt_d;       ctrl_q <= ctrl_d;
      dig_en_q <= dig_en_d;  dp_en_q <= dp_en_d;   raw_mode_q <= raw_mode_d;
      digits_lo_q <= digits_lo_d; digits_hi_q <= digits_hi_d; raw_q <= raw_d;
      raw_idx_q <= raw_idx_d;     sh_bright_q <= sh_bright_d; sh_gap_q <= sh_gap_d;
      sh_dig_en_q <= sh_dig_en_d; sh_dp_en_q <= sh_dp_en_d;   sh_raw_mode_q <= sh_raw_mode_d;
      sh_digits_q <= sh_digits_d; sh_raw_q <= sh_raw_d;       cnt_q <= cnt_d;
      idx_q <= idx_d;        frame_cnt_q <= frame_cnt_d;      an_q <= an_d;
      seg_q <= seg_d;        dp_out_q <= dp_out_d; frame_q <= frame_d;
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;
  assign o_an        = an_q;
  assign o_seg       = seg_q;
  assign o_dp        = dp_out_q;
  assign o_frame     = frame_q;

endmodule

// File: tb/tb_swervolf_sevseg_ctrl.sv
// Directed bench for swervolf_sevseg_ctrl with N_DIGITS=8, SCAN_DIV=64, BLANK_CYC=2.
module tb_swervolf_sevseg_ctrl;
  import swervolf_sevseg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;
  int         n_vec = 0;
  int         n_miscmp = 0;

  swervolf_sevseg_if bus ();

  swervolf_sevseg_ctrl #(.N_DIGITS(8), .SCAN_DIV(64), .BLANK_CYC(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .wb      (bus),
    .o_an    (an),
    .o_seg   (seg),
    .o_dp    (dp),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel,
                         input logic we, output logic [31:0] rdat);
    int waited = 0;
    bus.i_wb_adr = {r, 2'b00};
    bus.i_wb_dat = d;
    bus.i_wb_sel = sel;
    bus.i_wb_we  = we;
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!bus.o_wb_ack && waited < 8);
    if (!bus.o_wb_ack) check_vec("wb_ack_timeout", 32'(bus.o_wb_ack), 32'd1);
    rdat = bus.o_wb_rdt;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(r, d, sel, 1'b1, dummy);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] r, input logic [31:0] exp);
    logic [31:0] rdat;
    wb_xfer(r, 32'd0, 4'hF, 1'b0, rdat);
    check_vec(tag, rdat, exp);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame && n < 1200);
    if (!frame) check_vec("frame_timeout", 32'(frame), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lit_cnt;
    logic [7:0] an_s [64];
    bus.i_wb_adr = '0; bus.i_wb_dat = '0; bus.i_wb_sel = '0;
    bus.i_wb_we = 1'b0; bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_vec("rst_an", 32'(an), 32'hFF);
    check_vec("rst_seg", 32'(seg), 32'h7F);
    check_vec("rst_dp", 32'(dp), 32'd1);
    check_vec("rst_frame", 32'(frame), 32'd0);
    check_vec("rst_ack", 32'(bus.o_wb_ack), 32'd0);
    check_vec("rst_rdt", bus.o_wb_rdt, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) wb_read($sformatf("rst_reg%0d", r), 3'(r), 32'd0);

    // Basic scan: 8 digits, 64 cycles each, full brightness
    wb_write(REG_DIGITS_LO, 32'h76543210, 4'hF);
    wb_write(REG_DIG_EN, 32'hFF, 4'hF);
    wb_write(REG_CTRL, 32'h0F1, 4'hF);
    step(1);
    check_vec("scan_frame_first", 32'(frame), 32'd1);
    check_vec("scan_d0_an", 32'(an), 32'hFE);
    check_vec("scan_d0_seg", 32'(seg), 32'h01);
    step(128);
    check_vec("scan_d2_an", 32'(an), 32'hFB);
    check_vec("scan_d2_seg", 32'(seg), 32'h12);
    check_vec("scan_d2_noframe", 32'(frame), 32'd0);
    step(63);
    check_vec("scan_d2_end_an", 32'(an), 32'hFB);
    step(1);
    check_vec("scan_d3_an", 32'(an), 32'hF7);
    check_vec("scan_d3_seg", 32'(seg), 32'h06);
    step(320);
    check_vec("scan_frame_512", 32'(frame), 32'd1);
    check_vec("scan_wrap_an", 32'(an), 32'hFE);
    wb_read("status_frame1", REG_STATUS, 32'h0000_0100);

    // PWM brightness 3 with blanking gap
    wb_write(REG_CTRL, 32'h131, 4'hF);
    wait_frame();
    wait_frame();
    lit_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      an_s[i] = an;
      if (an != 8'hFF) lit_cnt++;
      if (i == 0) check_vec("pwm_c0_seg", 32'(seg), 32'h7F);
      step(1);
    end
    check_vec("pwm_c0_an", 32'(an_s[0]), 32'hFF);
    check_vec("pwm_c1_an", 32'(an_s[1]), 32'hFF);
    check_vec("pwm_c2_an", 32'(an_s[2]), 32'hFE);
    check_vec("pwm_c15_an", 32'(an_s[15]), 32'hFE);
    check_vec("pwm_c16_an", 32'(an_s[16]), 32'hFF);
    check_vec("pwm_lit_cycles", 32'(lit_cnt), 32'd14);

    // Shadow registers: mid-frame and boundary-coincident writes
    wb_write(REG_CTRL, 32'h0F1, 4'hF);
    wait_frame();
    wait_frame();
    wb_write(REG_DIGITS_LO, 32'h89ABCDEF, 4'hF);
    check_vec("shadow_d0_old", 32'(seg), 32'h01);
    step(63);
    check_vec("shadow_d1_old", 32'(seg), 32'h4F);
    wait_frame();
    check_vec("shadow_d0_new", 32'(seg), 32'h38);
    step(510);
    wb_write(REG_DIGITS_LO, 32'h00000055, 4'hF);
    wait_frame();
    check_vec("bnd_write_still_old", 32'(seg), 32'h38);
    wait_frame();
    check_vec("bnd_write_shown", 32'(seg), 32'h24);

    // Raw segments, decimal point, masking and byte lanes
    wb_write(REG_RAW_WR, 32'h0000_0549, 4'hF);
    wb_write(REG_RAW_WR, 32'h0000_0C7F, 4'hF);
    wb_write(REG_RAW_MODE, 32'h20, 4'hF);
    wb_write(REG_DP, 32'h0000_FF20, 4'hF);
    wb_write(REG_DIG_EN, 32'hFFFF_FFFF, 4'hF);
    wb_write(REG_DIGITS_HI, 32'hAABBCCDD, 4'b0101);
    wb_read("raw_wr_last_idx", REG_RAW_WR, 32'h0000_0500);
    wb_read("dp_masked", REG_DP, 32'h20);
    wb_read("raw_mode_rd", REG_RAW_MODE, 32'h20);
    wb_read("dig_en_masked", REG_DIG_EN, 32'hFF);
    wb_read("digits_hi_lanes", REG_DIGITS_HI, 32'h00BB00DD);
    wait_frame();
    wait_frame();
    step(320);
    check_vec("raw_d5_an", 32'(an), 32'hDF);
    check_vec("raw_d5_seg", 32'(seg), 32'h36);
    check_vec("raw_d5_dp", 32'(dp), 32'd0);
    step(64);
    check_vec("raw_d6_an", 32'(an), 32'hBF);
    check_vec("raw_d6_seg", 32'(seg), 32'h01);
    check_vec("raw_d6_dp", 32'(dp), 32'd1);

    // Disable blanks everything
    wb_write(REG_CTRL, 32'h0, 4'hF);
    step(1);
    check_vec("dis_an", 32'(an), 32'hFF);
    check_vec("dis_seg", 32'(seg), 32'h7F);
    check_vec("dis_dp", 32'(dp), 32'd1);
    check_vec("dis_frame", 32'(frame), 32'd0);

    // Reset mid-slot with a write pending
    wb_write(REG_CTRL, 32'h0F1, 4'hF);
    step(10);
    check_vec("pre_rst_an", 32'(an), 32'hFE);
    bus.i_wb_adr = {REG_DIG_EN, 2'b00};
    bus.i_wb_dat = 32'h0F;
    bus.i_wb_sel = 4'hF;
    bus.i_wb_we  = 1'b1;
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_vec("midrst_an", 32'(an), 32'hFF);
    check_vec("midrst_seg", 32'(seg), 32'h7F);
    check_vec("midrst_dp", 32'(dp), 32'd1);
    check_vec("midrst_ack", 32'(bus.o_wb_ack), 32'd0);
    @(posedge clk);
    #1;
    check_vec("midrst_ack_held", 32'(bus.o_wb_ack), 32'd0);
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    wb_read("midrst_dig_en", REG_DIG_EN, 32'd0);
    wb_read("midrst_ctrl", REG_CTRL, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
